game_ctrl: RTL

- Parametrised game sequencer for the snake datapath. It replaces the fixed-rate stepping and score handling of the previous generation.
- Owns the game state machine (idle/run/pause/over) and a speed-level tick generator.
- Issues step requests to the update engine over a req/ack handshake.
- Keeps a BCD score and a BCD high score, which feed the seven-segment display path directly.

---
 rtl/game_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Game sequencer for the snake datapath: idle/run/pause/over FSM, level-scaled
// step ticker with req/ack handshake, and saturating BCD score / high score.
module game_ctrl #(
  parameter int TICK_DIV_BASE   = 12500000,
  parameter int TICK_DIV_STEP   = 2500000,
  parameter int LEVELS          = 4,
  parameter int LEVEL_UP_FRUITS = 5,
  parameter int DIGITS          = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause_toggle,
  output logic                      step_req,
  input  logic                      step_ack,
  input  logic                      fruit_eaten,
  input  logic                      collision,
  output logic [1:0]                state,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic [4*DIGITS-1:0]       score_bcd,
  output logic [4*DIGITS-1:0]       high_bcd,
  output logic                      new_high
);
  localparam int LW = $clog2(LEVELS);
  localparam int CW = $clog2(TICK_DIV_BASE);
  localparam int FW = $clog2(LEVEL_UP_FRUITS + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [CW-1:0]   limit_r, limit_s;
  logic            req_r, req_s;
  logic            pend_r, pend_s;
  logic [LW-1:0]   level_r, level_s;
  logic [FW-1:0]   fruit_r, fruit_s;
  logic [SW-1:0]   score_r, score_s;
  logic [SW-1:0]   high_r, high_s;
  logic            new_high_r, new_high_s;
  logic            chk_r, chk_s;

  // Last counter value of a step period at the given level.
  function automatic logic [CW-1:0] period_last(input logic [LW-1:0] lvl);
    period_last = CW'(TICK_DIV_BASE - 1 - int'(lvl) * TICK_DIV_STEP);
  endfunction

  // BCD increment that holds at all nines instead of wrapping.
  function automatic logic [SW-1:0] bcd_inc_sat(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (v[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    bcd_inc_sat = carry ? v : r;
  endfunction

  // Next-state logic for the FSM, ticker, handshake, score and high score.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    limit_s    = limit_r;
    req_s      = req_r;
    pend_s     = pend_r;
    level_s    = level_r;
    fruit_s    = fruit_r;
    score_s    = score_r;
    high_s     = high_r;
    new_high_s = new_high_r;
    chk_s      = 1'b0;
    case (state_r)
      S_IDLE, S_OVER: begin
        // BCD digits order like binary, so a plain unsigned compare suffices.
        if (chk_r && (score_r > high_r)) begin
          high_s     = score_r;
          new_high_s = 1'b1;
        end else begin
          high_s = high_r;
        end
        if (start) begin
          state_s    = S_RUN;
          cnt_s      = {CW{1'b0}};
          limit_s    = period_last({LW{1'b0}});
          req_s      = 1'b0;
          pend_s     = 1'b0;
          level_s    = {LW{1'b0}};
          fruit_s    = {FW{1'b0}};
          score_s    = {SW{1'b0}};
          new_high_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (fruit_eaten) begin
          score_s = bcd_inc_sat(score_r);
          if (fruit_r == FW'(LEVEL_UP_FRUITS - 1)) begin
            fruit_s = {FW{1'b0}};
            level_s = (level_r == LW'(LEVELS - 1)) ? level_r : level_r + LW'(1);
          end else begin
            fruit_s = fruit_r + FW'(1);
          end
        end else begin
          score_s = score_r;
        end
        if (collision) begin
          state_s = S_OVER;
          req_s   = 1'b0;
          pend_s  = 1'b0;
          chk_s   = 1'b1;
        end else if (req_r) begin
          // A pause requested mid-step is held until the step completes.
          if (step_ack) begin
            req_s = 1'b0;
            if (pend_r || pause_toggle) begin
              state_s = S_PAUSE;
              pend_s  = 1'b0;
            end else begin
              state_s = S_RUN;
            end
          end else if (pause_toggle) begin
            pend_s = 1'b1;
          end else begin
            pend_s = pend_r;
          end
        end else if (pause_toggle) begin
          state_s = S_PAUSE;
        end else if (cnt_r == limit_r) begin
          cnt_s   = {CW{1'b0}};
          req_s   = 1'b1;
          limit_s = period_last(level_r);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_PAUSE: begin
        if (pause_toggle) begin
          state_s = S_RUN;
        end else begin
          state_s = S_PAUSE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear of everything, high score included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CW{1'b0}};
      limit_r    <= {CW{1'b0}};
      req_r      <= 1'b0;
      pend_r     <= 1'b0;
      level_r    <= {LW{1'b0}};
      fruit_r    <= {FW{1'b0}};
      score_r    <= {SW{1'b0}};
      high_r     <= {SW{1'b0}};
      new_high_r <= 1'b0;
      chk_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      limit_r    <= limit_s;
      req_r      <= req_s;
      pend_r     <= pend_s;
      level_r    <= level_s;
      fruit_r    <= fruit_s;
      score_r    <= score_s;
      high_r     <= high_s;
      new_high_r <= new_high_s;
      chk_r      <= chk_s;
    end
  end

  assign state     = state_r;
  assign step_req  = req_r;
  assign level     = level_r;
  assign score_bcd = score_r;
  assign high_bcd  = high_r;
  assign new_high  = new_high_r;

endmodule
